key_schedule_ctrl: RTL
======================

Name: key_schedule_ctrl

Overview:
- Sequential AES-128 key-expansion controller that sits directly upstream of the encryption round datapath.
- Accepts a 128-bit cipher key through a valid/ready handshake.
- Iterates the existing combinational single-round key step (module KeyGeneration; ports rc, key, keyout) once per clock for 10 rounds.
- Stores all 11 round keys in an internal register file and serves them to the round datapath through a registered, index-addressed read port.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; round keys stored = NUM_ROUNDS+1. Only 10 is supported.
- IDX_W, 4, width of round-key index and round counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  128  cipher key, MSB = byte 0.
- key_valid  in  1  key_in valid.
- key_ready  out  1  controller can accept a key; high in IDLE and DONE.
- clear  in  1  synchronous abort/invalidate.
- busy  out  1  high while in EXPAND.
- keys_ready  out  1  all 11 round keys valid.
- rd_idx  in  IDX_W  round-key index, 0..10.
- rd_key  out  128  round key for the rd_idx sampled on the previous edge.
- rd_valid  out  1  rd_key is valid.

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low, on rst_n.
  - While rst_n=0, state=IDLE, round counter=0, busy=0, keys_ready=0, rd_key=0, rd_valid=0.
  - key_ready=1, because it is decoded from state.
  - Register-file contents are not reset and are don't-care until written.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE, or DONE, with key_valid=1 and key_ready=1 at edge E0:
    - rk[0] <= key_in; working key cur <= key_in; rc <= 0.
    - Next state EXPAND; keys_ready drops to 0 at E0.
  - EXPAND, at each edge E1..E10:
    - rk[rc+1] <= step(rc, cur); cur <= step(rc, cur); rc <= rc+1.
    - After the edge that writes rk[10] (rc was 9), state becomes DONE and keys_ready <= 1.
    - busy=1 exactly during the 10 EXPAND cycles.
  - DONE: hold until a new key handshake (returns to EXPAND) or clear.
- Latency: keys_ready rises on edge E10, 10 cycles after acceptance.
- key_valid while in EXPAND is ignored (key_ready=0). No queuing; the source must hold key_valid.
- clear=1 at any edge: state <= IDLE, rc <= 0, keys_ready <= 0, rd_valid <= 0.
  - clear has priority over a simultaneous key handshake; that key is not accepted.
- Async reset mid-EXPAND: immediate IDLE, keys_ready=0. A partially written register file is never reported valid.
- Read port, registered with 1-cycle latency. At each edge:
  - If keys_ready=1 (pre-edge value) and rd_idx<=10: rd_key <= rk[rd_idx], rd_valid <= 1.
  - Otherwise: rd_key <= 0, rd_valid <= 0. This covers rd_idx 11..15, EXPAND, IDLE and clear.
- rc drives the step module directly. rc is never outside 0..9 while in EXPAND.
- All arithmetic is unsigned. rc wraps to 0 only via reload, never by overflow.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, read idx 1 then idx 10 after keys_ready:
  - keys_ready high exactly 10 cycles after acceptance.
  - rd_key = a0fafe1788542cb123a339392a6c7605, then d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_valid=1 both times.
- All-zero key, read idx 0, 1, 10:
  - 00000000000000000000000000000000
  - 62636363626363636263636362636363
  - b4ef5bcb3e92e21123e951cf6f8f188e
- Handshake behaviour:
  - key_valid held high through EXPAND with a second key: key_ready=0 and busy=1 for 10 cycles; second key not taken.
  - Second key accepted on the first DONE cycle: keys_ready drops next edge and rises again 10 cycles later with the second key's schedule.
- rd_idx=11 or 15 while keys_ready=1: rd_key=0 and rd_valid=0 next cycle.
- Disruption mid-expansion:
  - rst_n pulsed low after cycle 5 of EXPAND: outputs go to reset values immediately; reads return rd_valid=0 until a new full expansion completes.
  - clear asserted on the same edge as key_valid in DONE: state IDLE, keys_ready=0, key not accepted.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-expansion controller: one KeyGeneration step per cycle, 11 round keys held for the round datapath.
// Latency: keys_ready rises 10 cycles after key acceptance; rd_key is registered, 1 cycle after rd_idx.
// Backpressure: key_ready is low during EXPAND; the source must hold key_valid until key_ready is seen.

module KeyGeneration (
    input  logic [3:0]   rc,
    input  logic [127:0] key,
    output logic [127:0] keyout
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (product of x^2..x^128), then the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3, rot, temp;

    always_comb begin
        case (rc)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign {w0, w1, w2, w3} = key;
    assign rot  = {w3[23:0], w3[31:24]};
    assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                  ^ {rcon, 24'h000000};
    assign keyout[127:96] = w0 ^ temp;
    assign keyout[95:64]  = w1 ^ w0 ^ temp;
    assign keyout[63:32]  = w2 ^ w1 ^ w0 ^ temp;
    assign keyout[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ temp;

endmodule

module key_schedule_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [127:0]     key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             clear,
    output logic             busy,
    output logic             keys_ready,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [127:0]     rd_key,
    output logic             rd_valid
);

    localparam logic [IDX_W-1:0] LAST_RC = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rc;
    logic [127:0]     cur;
    logic [127:0]     step_key;
    logic [127:0]     rk [0:NUM_ROUNDS];
    logic             accept;
    logic             last_step;
    logic             rd_ok;

    KeyGeneration u_step (
        .rc     (rc),
        .key    (cur),
        .keyout (step_key)
    );

    assign key_ready = (state == IDLE) || (state == DONE);
    assign busy      = (state == EXPAND);
    // clear wins over a simultaneous handshake, so the key is simply not taken.
    assign accept    = key_valid && key_ready && !clear;
    assign last_step = busy && (rc == LAST_RC);
    assign rd_ok     = keys_ready && !clear && (rd_idx <= MAX_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (accept) state_nxt = EXPAND;
                EXPAND:     if (last_step) state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc         <= '0;
            cur        <= '0;
            keys_ready <= 1'b0;
        end else if (clear) begin
            rc         <= '0;
            keys_ready <= 1'b0;
        end else if (accept) begin
            rc         <= '0;
            cur        <= key_in;
            keys_ready <= 1'b0;
        end else if (busy) begin
            rc         <= rc + 1'b1;
            cur        <= step_key;
            keys_ready <= last_step;
        end
    end

    // Storage is deliberately unreset; keys_ready gates every read.
    always_ff @(posedge clk) begin
        if (accept)    rk[0]         <= key_in;
        else if (busy) rk[rc + 1'b1] <= step_key;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
        end else if (rd_ok) begin
            rd_key   <= rk[rd_idx];
            rd_valid <= 1'b1;
        end else begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
        end
    end

endmodule
